host_cmd_master: RTL

HOST_CMD_MASTER -- requirements
Module: host_cmd_master

---
 rtl/host_cmd_master.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/host_cmd_master.sv
// Host command master: turns one register-file / ALU command into a UART
// frame, collects the response bytes and reports completion or timeout.
//
// Ports:
//   CLK, RST             clock, asynchronous active-low reset
//   CMD_*                command handshake and fields (TIMEOUT=0: no timeout)
//   TX_DATA/TX_VALID     byte offered to the transmitter, TX_BUSY its status
//   RX_DATA/RX_VALID     bytes returned by the receiver
//   RSP_DATA/RSP_VALID   response value and completion pulse
//   RSP_TIMEOUT          pulse when the response does not arrive in time
module host_cmd_master #(
    parameter int BUS_WIDTH = 8,
    parameter int Reg_Addr  = 4,
    parameter int ALU_FUN   = 4,
    parameter int TO_W      = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [1:0]             CMD_TYPE,
    input  logic [Reg_Addr-1:0]    CMD_ADDR,
    input  logic [BUS_WIDTH-1:0]   CMD_DATA,
    input  logic [BUS_WIDTH-1:0]   CMD_OP_A,
    input  logic [BUS_WIDTH-1:0]   CMD_OP_B,
    input  logic [ALU_FUN-1:0]     CMD_FUN,
    input  logic [TO_W-1:0]        TIMEOUT,
    output logic [BUS_WIDTH-1:0]   TX_DATA,
    output logic                   TX_VALID,
    input  logic                   TX_BUSY,
    input  logic [BUS_WIDTH-1:0]   RX_DATA,
    input  logic                   RX_VALID,
    output logic [2*BUS_WIDTH-1:0] RSP_DATA,
    output logic                   RSP_VALID,
    output logic                   RSP_TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RESP,
        DONE
    } state_t;

    localparam logic [BUS_WIDTH-1:0] HDR_WR  = BUS_WIDTH'(8'hAA);
    localparam logic [BUS_WIDTH-1:0] HDR_RD  = BUS_WIDTH'(8'hBB);
    localparam logic [BUS_WIDTH-1:0] HDR_ALU = BUS_WIDTH'(8'hCC);
    localparam logic [BUS_WIDTH-1:0] HDR_FUN = BUS_WIDTH'(8'hDD);

    state_t state_q;
    state_t state_d;

    logic [1:0]             typ_q;
    logic [Reg_Addr-1:0]    addr_q;
    logic [BUS_WIDTH-1:0]   data_q;
    logic [BUS_WIDTH-1:0]   op_a_q;
    logic [BUS_WIDTH-1:0]   op_b_q;
    logic [ALU_FUN-1:0]     fun_q;
    logic [TO_W-1:0]        to_q;
    logic [1:0]             idx_q;
    logic [TO_W-1:0]        cnt_q;
    logic [2*BUS_WIDTH-1:0] rsp_q;

    logic [BUS_WIDTH-1:0] cur_byte;
    logic [BUS_WIDTH-1:0] addr_ext;
    logic [BUS_WIDTH-1:0] fun_ext;
    logic [1:0]           last_idx;
    logic                 last_tx;
    logic                 need_rsp;
    logic                 last_rx;
    logic                 timed_out;

    assign addr_ext = BUS_WIDTH'(addr_q);
    assign fun_ext  = BUS_WIDTH'(fun_q);

    // Frame byte for the current index and index of the final frame byte.
    always_comb begin
        cur_byte = '0;
        last_idx = 2'd0;
        unique case (typ_q)
            2'b00: begin
                last_idx = 2'd2;
                case (idx_q)
                    2'd0:    cur_byte = HDR_WR;
                    2'd1:    cur_byte = addr_ext;
                    default: cur_byte = data_q;
                endcase
            end
            2'b01: begin
                last_idx = 2'd1;
                cur_byte = (idx_q == 2'd0) ? HDR_RD : addr_ext;
            end
            2'b10: begin
                last_idx = 2'd3;
                case (idx_q)
                    2'd0:    cur_byte = HDR_ALU;
                    2'd1:    cur_byte = op_a_q;
                    2'd2:    cur_byte = op_b_q;
                    default: cur_byte = fun_ext;
                endcase
            end
            2'b11: begin
                last_idx = 2'd1;
                cur_byte = (idx_q == 2'd0) ? HDR_FUN : fun_ext;
            end
        endcase
    end

    assign last_tx  = (idx_q == last_idx);
    assign need_rsp = (typ_q != 2'b00);
    // RF read expects one byte (slot 0), ALU commands two (slots 0,1).
    assign last_rx  = (idx_q == {1'b0, typ_q[1]});
    // A byte arriving on the expiry cycle takes precedence.
    assign timed_out = (state_q == RESP) && (to_q != '0) &&
                       (cnt_q == to_q) && !RX_VALID;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (CMD_VALID) state_d = SEND;
            end
            SEND: begin
                if (TX_BUSY) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (!TX_BUSY) begin
                    if (!last_tx)      state_d = SEND;
                    else if (need_rsp) state_d = RESP;
                    else               state_d = DONE;
                end
            end
            RESP: begin
                if (RX_VALID && last_rx) state_d = DONE;
                else if (timed_out)      state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CMD_READY   = (state_q == IDLE);
        TX_VALID    = (state_q == SEND);
        TX_DATA     = (state_q == SEND) ? cur_byte : '0;
        RSP_VALID   = (state_q == DONE);
        RSP_TIMEOUT = timed_out;
        RSP_DATA    = rsp_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            typ_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            fun_q  <= '0;
            to_q   <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            rsp_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (CMD_VALID) begin
                        typ_q  <= CMD_TYPE;
                        addr_q <= CMD_ADDR;
                        data_q <= CMD_DATA;
                        op_a_q <= CMD_OP_A;
                        op_b_q <= CMD_OP_B;
                        fun_q  <= CMD_FUN;
                        to_q   <= TIMEOUT;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        rsp_q  <= '0;
                    end
                end
                WAIT_TX: begin
                    if (!TX_BUSY) begin
                        // Index restarts at 0 to address response slots.
                        if (last_tx) begin
                            idx_q <= '0;
                            cnt_q <= '0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                RESP: begin
                    if (RX_VALID) begin
                        if (idx_q[0]) begin
                            rsp_q[2*BUS_WIDTH-1:BUS_WIDTH] <= RX_DATA;
                        end else begin
                            rsp_q[BUS_WIDTH-1:0] <= RX_DATA;
                        end
                        idx_q <= idx_q + 2'd1;
                        cnt_q <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
